// File: rtl/ssd_step_ctrl.sv
// ssd_step_ctrl - board front end for the pipelined CPU.
//
// Multiplexes a 16-bit slice of either regi or pcSSD onto a 4-digit
// seven-segment display. It also debounces the manual step button into a
// one-cycle stepPulse.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   regi       register value selected by the CPU's switch input
//   pcSSD      current PC from the CPU
//   showPc     1: display pcSSD, 0: display regi
//   upperHalf  1: display bits [31:16], 0: display bits [15:0]
//   stepBtn    raw asynchronous push button, active-high
//   stepPulse  one-cycle pulse per debounced press
//   an         digit enables, active-low, an[0] = rightmost digit
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low (lit on digit 3 while showing PC)
//
// Build option:
//   SSD_BLANK_LEADING_EN  blank leading-zero digits (digit 0 always shown)

module ssd_step_ctrl #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] regi,
    input  logic [31:0] pcSSD,
    input  logic        showPc,
    input  logic        upperHalf,
    input  logic        stepBtn,
    output logic        stepPulse,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // ---------------- scan and snapshot ----------------
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       digit;
    logic [15:0]      disp_reg;
    logic             disp_pc;
    logic             scan_wrap;
    logic [31:0]      src;
    logic [15:0]      slice;

    assign scan_wrap = (div_cnt == DIV_LAST);

    always_comb begin
        src   = showPc ? pcSSD : regi;
        slice = upperHalf ? src[31:16] : src[15:0];
    end

    // The value and its showPc flag are only captured as digit 3 finishes,
    // so a whole frame is always drawn from one consistent snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            digit    <= '0;
            disp_reg <= '0;
            disp_pc  <= 1'b0;
        end else if (scan_wrap) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
            if (digit == 2'd3) begin
                disp_reg <= slice;
                disp_pc  <= showPc;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    logic [3:0] nib;
    logic       blank;

    always_comb begin
        nib   = '0;
        blank = 1'b0;
        case (digit)
            2'd0: nib = disp_reg[3:0];
            2'd1: nib = disp_reg[7:4];
            2'd2: nib = disp_reg[11:8];
            default: nib = disp_reg[15:12];
        endcase
`ifdef SSD_BLANK_LEADING_EN
        // A digit is blank when it and every digit to its left are zero.
        case (digit)
            2'd0: blank = 1'b0;
            2'd1: blank = (disp_reg[15:4] == 12'h000);
            2'd2: blank = (disp_reg[15:8] == 8'h00);
            default: blank = (disp_reg[15:12] == 4'h0);
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << digit);
            seg <= blank ? 7'b1111111 : hex7(nib);
            dp  <= ~((digit == 2'd3) && disp_pc);
        end
    end

    // ---------------- step button debounce ----------------
    logic [1:0]       sync_q;
    logic             s;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pulse_next;

    assign s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            state     <= IDLE;
            cnt       <= '0;
            stepPulse <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], stepBtn};
            state     <= state_next;
            cnt       <= cnt_next;
            stepPulse <= pulse_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = WAIT_RELEASE;
                    cnt_next   = '0;
                end
            end
            WAIT_RELEASE: begin
                // Release bounce returns to PRESSED so it can never re-trigger.
                if (s) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ssd_step_ctrl.sv
module tb_ssd_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] regi;
    logic [31:0] pcSSD;
    logic        showPc;
    logic        upperHalf;
    logic        stepBtn;
    logic        stepPulse;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pulse_cnt;
    int pulse_at;
    int step_t;

    logic [3:0] an_t [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg [4];

`ifdef SSD_BLANK_LEADING_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    ssd_step_ctrl #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .regi(regi),
        .pcSSD(pcSSD),
        .showPc(showPc),
        .upperHalf(upperHalf),
        .stepBtn(stepBtn),
        .stepPulse(stepPulse),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive the button at one level for n cycles, tallying pulses.
    task automatic hold(input logic lvl, input int n);
        stepBtn = lvl;
        repeat (n) begin
            tick();
            step_t++;
            if (stepPulse === 1'b1) begin
                pulse_cnt++;
                if (pulse_at < 0) pulse_at = step_t;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL reset_an got=%b exp=1110", an); end
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got=%b exp=1", dp); end
        tests++; if (stepPulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got=%b exp=0", stepPulse); end
        reset = 1'b0;
        cyc = 0;
    endtask

    // First frame after reset: an rotates, dispReg still zero.
    task automatic test_scan();
        for (int k = 0; k < 16; k++) begin
            int i;
            logic [6:0] e;
            tick();
            i = k / 4;
            e = (BLANK_ON && i != 0) ? 7'b1111111 : 7'b1000000;
            tests++; if (an !== an_t[i]) begin fails++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, an_t[i]); end
            tests++; if (seg !== e) begin fails++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, seg, e); end
            tests++; if (dp !== 1'b1) begin fails++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", cyc, dp); end
        end
    endtask

    // pcSSD lower half A3C8, captured at the end of the first frame.
    task automatic test_pc_display();
        exp_seg = '{7'b0000000, 7'b1000110, 7'b0110000, 7'b0001000};
        for (int k = 0; k < 16; k++) begin
            int i;
            tick();
            i = k / 4;
            tests++; if (an !== an_t[i]) begin fails++; $display("FAIL pc_an cyc=%0d got=%b exp=%b", cyc, an, an_t[i]); end
            tests++; if (seg !== exp_seg[i]) begin fails++; $display("FAIL pc_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg[i]); end
            tests++; if (dp !== (i == 3 ? 1'b0 : 1'b1)) begin fails++; $display("FAIL pc_dp cyc=%0d got=%b exp=%b", cyc, dp, (i == 3 ? 1'b0 : 1'b1)); end
        end
    endtask

    task automatic test_regi_snapshot();
        regi = 32'hDEAD_0001; showPc = 1'b0; upperHalf = 1'b1;
        // Frame in progress keeps showing A3C8 with dp on digit 3.
        exp_seg = '{7'b0000000, 7'b1000110, 7'b0110000, 7'b0001000};
        for (int k = 0; k < 16; k++) begin
            int i;
            tick();
            i = k / 4;
            tests++; if (seg !== exp_seg[i]) begin fails++; $display("FAIL hold_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg[i]); end
            tests++; if (dp !== (i == 3 ? 1'b0 : 1'b1)) begin fails++; $display("FAIL hold_dp cyc=%0d got=%b exp=%b", cyc, dp, (i == 3 ? 1'b0 : 1'b1)); end
        end
        // DEAD frame; regi changes mid-frame without tearing.
        exp_seg = '{7'b0100001, 7'b0001000, 7'b0000110, 7'b0100001};
        for (int k = 0; k < 16; k++) begin
            int i;
            if (k == 4) regi = 32'h1234_5678;
            tick();
            i = k / 4;
            tests++; if (an !== an_t[i]) begin fails++; $display("FAIL regi_an cyc=%0d got=%b exp=%b", cyc, an, an_t[i]); end
            tests++; if (seg !== exp_seg[i]) begin fails++; $display("FAIL regi_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg[i]); end
            tests++; if (dp !== 1'b1) begin fails++; $display("FAIL regi_dp cyc=%0d got=%b exp=1", cyc, dp); end
        end
        // Next frame picks up 1234.
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        for (int k = 0; k < 16; k++) begin
            int i;
            tick();
            i = k / 4;
            tests++; if (seg !== exp_seg[i]) begin fails++; $display("FAIL next_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg[i]); end
        end
    endtask

    task automatic test_step_hold();
        pulse_cnt = 0; pulse_at = -1; step_t = 0;
        hold(1'b1, 20);
        tests++; if (pulse_cnt !== 1) begin fails++; $display("FAIL hold_pulses got=%0d exp=1", pulse_cnt); end
        tests++; if (pulse_at !== 11) begin fails++; $display("FAIL hold_latency got=%0d exp=11", pulse_at); end
        pulse_cnt = 0;
        hold(1'b0, 30);
        tests++; if (pulse_cnt !== 0) begin fails++; $display("FAIL release_pulses got=%0d exp=0", pulse_cnt); end
    endtask

    task automatic test_glitch();
        pulse_cnt = 0; pulse_at = -1; step_t = 0;
        hold(1'b1, 5);
        hold(1'b0, 1);
        hold(1'b1, 5);
        hold(1'b0, 25);
        tests++; if (pulse_cnt !== 0) begin fails++; $display("FAIL glitch_pulses got=%0d exp=0", pulse_cnt); end
    endtask

    task automatic test_bounce();
        pulse_cnt = 0; pulse_at = -1; step_t = 0;
        hold(1'b1, 14);
        hold(1'b0, 3);
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 2);
        hold(1'b0, 25);
        tests++; if (pulse_cnt !== 1) begin fails++; $display("FAIL bounce_pulses got=%0d exp=1", pulse_cnt); end
        tests++; if (pulse_at !== 11) begin fails++; $display("FAIL bounce_latency got=%0d exp=11", pulse_at); end
    endtask

    task automatic test_back_to_back();
        pulse_cnt = 0; pulse_at = -1; step_t = 0;
        hold(1'b1, 14);
        hold(1'b0, 25);
        tests++; if (pulse_cnt !== 1) begin fails++; $display("FAIL second_press got=%0d exp=1", pulse_cnt); end
    endtask

    task automatic test_reset_midop();
        pulse_cnt = 0; pulse_at = -1; step_t = 0;
        hold(1'b1, 9);
        reset = 1'b1;
        tick();
        tests++; if (stepPulse !== 1'b0) begin fails++; $display("FAIL mid_pulse got=%b exp=0", stepPulse); end
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL mid_an got=%b exp=1110", an); end
        tests++; if (seg !== 7'b1000000) begin fails++; $display("FAIL mid_seg got=%b exp=1000000", seg); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL mid_dp got=%b exp=1", dp); end
        reset = 1'b0;
        cyc = 0;
        pulse_cnt = 0; pulse_at = -1; step_t = 0;
        hold(1'b1, 14);
        tests++; if (pulse_cnt !== 1) begin fails++; $display("FAIL mid_repress got=%0d exp=1", pulse_cnt); end
        tests++; if (pulse_at !== 11) begin fails++; $display("FAIL mid_latency got=%0d exp=11", pulse_at); end
        hold(1'b0, 25);
    endtask

`ifdef SSD_BLANK_LEADING_EN
    task automatic test_blank();
        regi = 32'h0000_0050; showPc = 1'b0; upperHalf = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0;
        repeat (16) tick();
        exp_seg = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
        for (int k = 0; k < 16; k++) begin
            int i;
            tick();
            i = k / 4;
            tests++; if (an !== an_t[i]) begin fails++; $display("FAIL blank_an cyc=%0d got=%b exp=%b", cyc, an, an_t[i]); end
            tests++; if (seg !== exp_seg[i]) begin fails++; $display("FAIL blank_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg[i]); end
        end
        regi = 32'h0;
        repeat (16) tick();
        exp_seg = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        for (int k = 0; k < 16; k++) begin
            int i;
            tick();
            i = k / 4;
            tests++; if (seg !== exp_seg[i]) begin fails++; $display("FAIL blank_zero cyc=%0d got=%b exp=%b", cyc, seg, exp_seg[i]); end
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        regi      = 32'h0;
        pcSSD     = 32'h0040_A3C8;
        showPc    = 1'b1;
        upperHalf = 1'b0;
        stepBtn   = 1'b0;
        test_reset();
        test_scan();
        test_pc_display();
        test_regi_snapshot();
        test_step_hold();
        test_glitch();
        test_bounce();
        test_back_to_back();
        test_reset_midop();
`ifdef SSD_BLANK_LEADING_EN
        test_blank();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
